ad9866_spi_target: RTL

SPI register-file responder for the AD9866 4-wire serial control port: the device end of the link the AD9866 configuration master drives. It runs on the FPGA clock and decodes 16-bit frames from `sclk`/`sen_n`/`sdio`, and it holds a 20-entry × 8-bit register image. On reads it returns data on `sdo`. Two uses: the bench model for the configuration master, and an on-chip shadow that exposes the programmed RX gain and per-write strobes to the rest of the design.

---
 rtl/ad9866_spi_target.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ad9866_spi_target.sv
// AD9866 serial control port target: decodes 16-bit frames from sclk/sen_n/sdio on the
// system clock, keeps a NREGS x 8 register image, and returns read data on sdo in 4-wire mode.
module ad9866_spi_target #(
    parameter int         NREGS     = 20,
    parameter logic [4:0] GAIN_ADDR = 5'h0A
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               sclk_i,
    input  logic               sen_n_i,
    input  logic               sdio_i,
    output logic               sdo_o,
    output logic [NREGS*8-1:0] regs_o,
    output logic [5:0]         rx_gain_o,
    output logic               wr_stb_o,
    output logic [4:0]         wr_addr_o,
    output logic [7:0]         wr_data_o,
    output logic               frame_err_o
);

    // state | meaning
    // IDLE  | waiting for sen_n falling edge; captures ignored
    // SHIFT | frame open; captures shift sdio in, end edge commits or aborts
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [5:0] NREGS_W = 6'(NREGS);

    state_t      state_q, state_d;
    logic        sclk_dly_q, sen_n_dly_q;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [15:0] shift_q, shift_d;
    logic        rw_q, rw_d;
    logic [7:0]  rdbyte_q, rdbyte_d;
    logic        sdo_q, sdo_d;
    logic [7:0]  regs_q [NREGS];
    logic [7:0]  regs_d [NREGS];
    logic        wr_stb_q, wr_stb_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        frame_err_q, frame_err_d;

    logic        start_edge, end_edge, capture;
    logic        rd_mode;
    logic [4:0]  rd_addr;
    logic [2:0]  rd_bit;

    assign start_edge = sen_n_dly_q & ~sen_n_i;
    assign end_edge   = ~sen_n_dly_q & sen_n_i;
    assign capture    = sclk_i & ~sclk_dly_q;
    // read data only leaves the block for read frames in 4-wire mode
    assign rd_mode    = rw_q & regs_q[0][7];
    assign rd_addr    = {shift_q[3:0], sdio_i};
    assign rd_bit     = 3'(5'd14 - bitcnt_q);

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        rdbyte_d    = rdbyte_q;
        sdo_d       = sdo_q;
        regs_d      = regs_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (start_edge) begin
                    state_d  = SHIFT;
                    bitcnt_d = 5'd0;
                    shift_d  = 16'h0000;
                    rw_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (end_edge) begin
                    state_d = IDLE;
                    sdo_d   = 1'b0;
                    if (bitcnt_q != 5'd16 || shift_q[14:13] != 2'b00) begin
                        frame_err_d = 1'b1;
                    end else if (!shift_q[15] && ({1'b0, shift_q[12:8]} < NREGS_W)) begin
                        regs_d[shift_q[12:8]] = shift_q[7:0];
                        wr_stb_d  = 1'b1;
                        wr_addr_d = shift_q[12:8];
                        wr_data_d = shift_q[7:0];
                    end
                end else if (capture && !sen_n_i) begin
                    shift_d = {shift_q[14:0], sdio_i};
                    if (bitcnt_q != 5'd17) begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                    if (bitcnt_q == 5'd0) begin
                        rw_d = sdio_i;
                    end
                    if (bitcnt_q == 5'd7) begin
                        rdbyte_d = ({1'b0, rd_addr} < NREGS_W) ? regs_q[rd_addr] : 8'h00;
                        sdo_d    = rd_mode & rdbyte_d[7];
                    end else if (bitcnt_q >= 5'd8 && bitcnt_q <= 5'd14) begin
                        sdo_d = rd_mode & rdbyte_q[rd_bit];
                    end else begin
                        sdo_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            sclk_dly_q  <= 1'b0;
            sen_n_dly_q <= 1'b0;
            bitcnt_q    <= 5'd0;
            shift_q     <= 16'h0000;
            rw_q        <= 1'b0;
            rdbyte_q    <= 8'h00;
            sdo_q       <= 1'b0;
            regs_q      <= '{default: 8'h00};
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_dly_q  <= sclk_i;
            sen_n_dly_q <= sen_n_i;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            rdbyte_q    <= rdbyte_d;
            sdo_q       <= sdo_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_regs
        assign regs_o[8*k +: 8] = regs_q[k];
    end

    assign rx_gain_o   = regs_q[GAIN_ADDR][5:0];
    assign sdo_o       = sdo_q;
    assign wr_stb_o    = wr_stb_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign frame_err_o = frame_err_q;

endmodule
